// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers for the multicycle MIPS datapath.
// Optional MDU_EARLY_TERM_EN: multiplies leave RUN once the remaining multiplier bits are zero.
module mult_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       hilo_wr,
   input  logic [WIDTH-1:0] hilo_wdata,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

   state_t             state, state_nxt;
   logic               is_div, neg_res, neg_rem, dz;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH:0]     rem;

   logic               signed_op, op_div, b_zero, last_iter, rem_ge;
   logic [WIDTH-1:0]   mag_a, mag_b, quo_fix, rem_fix;
   logic [WIDTH:0]     rem_sh;
   logic [2*WIDTH-1:0] prod_fix;

   assign signed_op = ~op[0];
   assign op_div    = op[1];
   assign b_zero    = (b == '0);
   assign mag_a     = (signed_op && a[WIDTH-1]) ? -a : a;
   assign mag_b     = (signed_op && b[WIDTH-1]) ? -b : b;

   // Division keeps the dividend/quotient in acc[WIDTH-1:0] and the divisor in mplier.
   assign rem_sh = {rem[WIDTH-1:0], acc[WIDTH-1]};
   assign rem_ge = (rem_sh >= {1'b0, mplier});

   assign prod_fix = neg_res ? -acc : acc;
   assign quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign rem_fix  = neg_rem ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

`ifdef MDU_EARLY_TERM_EN
   assign last_iter = (cnt == CNT_W'(WIDTH - 1)) || (!is_div && (mplier[WIDTH-1:1] == '0));
`else
   assign last_iter = (cnt == CNT_W'(WIDTH - 1));
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // A divide by zero passes through FIX with the HI/LO write suppressed, so done lands after E1.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = (op_div && b_zero) ? FIX : RUN;
         RUN: begin
            busy = 1'b1;
            if (last_iter) state_nxt = FIX;
         end
         FIX: begin
            busy      = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         is_div   <= 1'b0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         dz       <= 1'b0;
         div_zero <= 1'b0;
         cnt      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         acc      <= '0;
         rem      <= '0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  is_div   <= op_div;
                  neg_res  <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_rem  <= signed_op & a[WIDTH-1];
                  dz       <= op_div & b_zero;
                  div_zero <= 1'b0;
                  cnt      <= '0;
                  mcand    <= {{WIDTH{1'b0}}, mag_a};
                  mplier   <= mag_b;
                  acc      <= op_div ? {{WIDTH{1'b0}}, mag_a} : '0;
                  rem      <= '0;
               end else begin
                  if (hilo_wr[1]) hi <= hilo_wdata;
                  if (hilo_wr[0]) lo <= hilo_wdata;
               end
            end
            RUN: begin
               cnt <= cnt + 1'b1;
               if (is_div) begin
                  rem             <= rem_ge ? (rem_sh - {1'b0, mplier}) : rem_sh;
                  acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], rem_ge};
               end else begin
                  if (mplier[0]) acc <= acc + mcand;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
               end
            end
            FIX: begin
               if (dz) begin
                  div_zero <= 1'b1;
               end else if (is_div) begin
                  lo <= quo_fix;
                  hi <= rem_fix;
               end else begin
                  hi <= prod_fix[2*WIDTH-1:WIDTH];
                  lo <= prod_fix[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit (WIDTH=32): vector table, corner sequences, random ops vs model.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic [1:0]  hilo_wr;
   logic [31:0] hilo_wdata;
   logic        busy, done, div_zero;
   logic [31:0] hi, lo;

   int checks = 0;
   int failures = 0;
   logic [31:0] m_hi, m_lo;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .hilo_wr(hilo_wr), .hilo_wdata(hilo_wdata),
      .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] eh;
      logic [31:0] el;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, expv);
      end
   endtask

   // Cycles from the start-sampling edge to the cycle in which done is seen.
   function automatic int exp_lat(input logic [1:0] o, input logic [31:0] xb);
      logic [31:0] m;
      int n;
      if (o[1] && xb == 32'h0) return 2;
`ifdef MDU_EARLY_TERM_EN
      if (!o[1]) begin
         m = (!o[0] && xb[31]) ? -xb : xb;
         n = 1;
         for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
         return n + 2;
      end
`else
      m = xb;
      n = 0;
`endif
      return 34;
   endfunction

   task automatic model_op(input logic [1:0] o, input logic [31:0] xa, input logic [31:0] xb,
                           output logic [31:0] eh, output logic [31:0] el, output logic edz);
      longint sp;
      longint unsigned up;
      edz = 1'b0;
      eh  = m_hi;
      el  = m_lo;
      case (o)
         2'd0: begin
            sp = longint'($signed(xa)) * longint'($signed(xb));
            eh = sp[63:32]; el = sp[31:0];
         end
         2'd1: begin
            up = {32'h0, xa} * {32'h0, xb};
            eh = up[63:32]; el = up[31:0];
         end
         2'd2: begin
            if (xb == 32'h0) edz = 1'b1;
            else begin
               sp = longint'($signed(xa)) / longint'($signed(xb));
               el = sp[31:0];
               sp = longint'($signed(xa)) % longint'($signed(xb));
               eh = sp[31:0];
            end
         end
         default: begin
            if (xb == 32'h0) edz = 1'b1;
            else begin
               el = xa / xb;
               eh = xa % xb;
            end
         end
      endcase
      m_hi = eh;
      m_lo = el;
   endtask

   task automatic do_op(input logic [1:0] o, input logic [31:0] xa, input logic [31:0] xb,
                        input bit disturb, input logic [1:0] hw,
                        input logic [31:0] eh, input logic [31:0] el, input logic edz,
                        input string nm);
      int lat, bcnt;
      lat  = 0;
      bcnt = 0;
      @(negedge clk);
      op = o; a = xa; b = xb; start = 1'b1;
      hilo_wr = hw; hilo_wdata = 32'hDEADBEEF;
      @(posedge clk);
      #1;
      start = 1'b0; hilo_wr = 2'b00;
      a = $urandom; b = $urandom;
      for (int k = 1; k <= 200; k++) begin
         @(negedge clk);
         if (k == 1) chk({nm, "_dz_clear"}, 64'(div_zero), 64'(0));
         if (disturb) begin
            if (k == 10) begin start = 1'b1; op = 2'd2; end
            if (k == 11) start = 1'b0;
            if (k == 12) begin hilo_wr = 2'b01; hilo_wdata = 32'hFFFF0000; end
            if (k == 13) hilo_wr = 2'b00;
         end
         if (done) begin
            lat = k;
            break;
         end
         if (busy) bcnt++;
      end
      chk({nm, "_latency"}, 64'(lat), 64'(exp_lat(o, xb)));
      chk({nm, "_busy_cycles"}, 64'(bcnt), 64'(exp_lat(o, xb) - 1));
      chk({nm, "_busy_at_done"}, 64'(busy), 64'(0));
      chk({nm, "_hi"}, 64'(hi), 64'(eh));
      chk({nm, "_lo"}, 64'(lo), 64'(el));
      chk({nm, "_div_zero"}, 64'(div_zero), 64'(edz));
      @(negedge clk);
      chk({nm, "_done_pulse"}, 64'(done), 64'(0));
      chk({nm, "_idle_after"}, 64'(busy), 64'(0));
   endtask

   vec_t vecs[10];

   initial begin
      logic [1:0]  ro;
      logic [31:0] ra, rb, eh, el;
      logic        edz;
      int          sel;

      vecs[0] = '{2'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
      vecs[1] = '{2'd1, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
      vecs[2] = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3] = '{2'd3, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
      vecs[4] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[5] = '{2'd0, 32'h00000006, 32'h00000007, 32'h00000000, 32'h0000002A};
      vecs[6] = '{2'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
      vecs[7] = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[8] = '{2'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      vecs[9] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};

      reset = 1'b0; start = 1'b0; op = 2'd0; a = '0; b = '0;
      hilo_wr = 2'b00; hilo_wdata = '0;
      m_hi = '0; m_lo = '0;
      repeat (3) @(negedge clk);
      chk("reset_busy", 64'(busy), 64'(0));
      chk("reset_done", 64'(done), 64'(0));
      chk("reset_div_zero", 64'(div_zero), 64'(0));
      chk("reset_hi", 64'(hi), 64'(0));
      chk("reset_lo", 64'(lo), 64'(0));
      reset = 1'b1;

      for (int i = 0; i < 10; i++) begin
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 2'b00, vecs[i].eh, vecs[i].el, 1'b0,
               $sformatf("vec%0d", i));
         m_hi = vecs[i].eh;
         m_lo = vecs[i].el;
      end

      // mthi/mtlo writes, then divide by zero leaves them untouched; hilo_wr alongside start is dropped
      @(negedge clk); hilo_wr = 2'b11; hilo_wdata = 32'h12345678;
      @(negedge clk); hilo_wr = 2'b00;
      chk("mthilo_both_hi", 64'(hi), 64'h12345678);
      chk("mthilo_both_lo", 64'(lo), 64'h12345678);
      hilo_wr = 2'b10; hilo_wdata = 32'hAAAA0000;
      @(negedge clk); hilo_wr = 2'b01; hilo_wdata = 32'h00005555;
      @(negedge clk); hilo_wr = 2'b00;
      chk("mthi_hi", 64'(hi), 64'hAAAA0000);
      chk("mtlo_lo", 64'(lo), 64'h00005555);
      m_hi = 32'hAAAA0000; m_lo = 32'h00005555;
      do_op(2'd3, 32'h7, 32'h0, 1'b0, 2'b11, 32'hAAAA0000, 32'h00005555, 1'b1, "divzero");
      do_op(2'd3, 32'h7, 32'h2, 1'b0, 2'b00, 32'h1, 32'h3, 1'b0, "after_dz");
      m_hi = 32'h1; m_lo = 32'h3;

      // start held high: ignored in DONE, re-accepted the cycle after
      @(negedge clk); op = 2'd3; a = 32'h7; b = 32'h0; start = 1'b1;
      @(negedge clk); chk("hold_c1_busy", 64'(busy), 64'(1));
      @(negedge clk); chk("hold_c2_done", 64'(done), 64'(1));
      @(negedge clk); chk("hold_c3_busy", 64'(busy), 64'(0));
      chk("hold_c3_done", 64'(done), 64'(0));
      @(negedge clk); chk("hold_c4_busy", 64'(busy), 64'(1));
      start = 1'b0;
      @(negedge clk); chk("hold_c5_done", 64'(done), 64'(1));
      chk("hold_c5_dz", 64'(div_zero), 64'(1));
      chk("hold_hi", 64'(hi), 64'h1);
      @(negedge clk);

      do_op(2'd1, 32'h3, 32'h80000005, 1'b1, 2'b00, 32'h1, 32'h8000000F, 1'b0, "disturb");
      m_hi = 32'h1; m_lo = 32'h8000000F;

      // asynchronous reset mid-RUN aborts and clears HI/LO
      @(negedge clk); op = 2'd1; a = 32'h3; b = 32'h80000005; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (14) @(negedge clk);
      chk("pre_reset_busy", 64'(busy), 64'(1));
      #2 reset = 1'b0;
      #1;
      chk("async_reset_busy", 64'(busy), 64'(0));
      chk("async_reset_done", 64'(done), 64'(0));
      chk("async_reset_hi", 64'(hi), 64'(0));
      chk("async_reset_lo", 64'(lo), 64'(0));
      @(negedge clk); @(negedge clk); reset = 1'b1;
      m_hi = '0; m_lo = '0;
      do_op(2'd0, 32'h6, 32'h7, 1'b0, 2'b00, 32'h0, 32'h2A, 1'b0, "post_reset");
      m_hi = 32'h0; m_lo = 32'h2A;

      for (int i = 0; i < 40; i++) begin
         ro  = 2'($urandom_range(0, 3));
         ra  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
         sel = $urandom_range(0, 6);
         case (sel)
            0:       rb = 32'h0;
            1:       rb = 32'($urandom_range(0, 3));
            2:       rb = 32'h80000000;
            3:       rb = 32'hFFFFFFFF;
            default: rb = $urandom;
         endcase
         model_op(ro, ra, rb, eh, el, edz);
         do_op(ro, ra, rb, 1'b0, 2'b00, eh, el, edz, $sformatf("rnd%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
